// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky errors, flush.
// Latency: a write is visible (o_empty=0) after its edge; FWFT=0 read data one cycle after the read edge, FWFT=1 combinational.
// Backpressure: writes are dropped while full (o_overflow latches) and reads ignored while empty (o_underflow latches).
//
// Ports:
//   CLK, RST         clock and synchronous active-high reset
//   i_flush          synchronous flush: empties the queue and clears the error flags
//   i_w_inc/i_w_data write request and data
//   i_r_inc          read request (FWFT=1: acknowledge of the presented word)
//   o_r_data/o_r_valid  read data and its qualifier
//   o_full/o_empty/o_almost_full/o_almost_empty/o_count  decodes of the registered occupancy
//   o_overflow/o_underflow  sticky rejected-access flags

module sync_fifo #(
    parameter int D_SIZE   = 8,
    parameter int A_SIZE   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_flush,
    input  logic              i_w_inc,
    input  logic [D_SIZE-1:0] i_w_data,
    input  logic              i_r_inc,
    output logic [D_SIZE-1:0] o_r_data,
    output logic              o_r_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic [A_SIZE:0]   o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int DEPTH = 1 << A_SIZE;

    // Thresholds sized to the count register so the compares are width-exact.
    localparam logic [A_SIZE:0]   CNT_FULL = (A_SIZE+1)'(DEPTH);
    localparam logic [A_SIZE:0]   AF_THR   = (A_SIZE+1)'(AF_LEVEL);
    localparam logic [A_SIZE:0]   AE_THR   = (A_SIZE+1)'(AE_LEVEL);
    localparam logic [A_SIZE:0]   CNT_ONE  = (A_SIZE+1)'(1);
    localparam logic [A_SIZE-1:0] PTR_ONE  = A_SIZE'(1);

    logic [D_SIZE-1:0] mem [DEPTH];
    logic [A_SIZE-1:0] wptr;
    logic [A_SIZE-1:0] rptr;
    logic [A_SIZE:0]   count;
    logic              wr_acc;
    logic              rd_acc;

    // Status is a pure decode of the registered count, so it moves on the
    // same edge that commits the access.
    assign o_count        = count;
    assign o_full         = (count == CNT_FULL);
    assign o_empty        = (count == '0);
    assign o_almost_full  = (count >= AF_THR);
    assign o_almost_empty = (count <= AE_THR);

    // Accept decisions use start-of-cycle flags: at full a simultaneous
    // read still drains, at empty a simultaneous write still fills. Flush
    // suppresses both so nothing is stored or popped in a flush cycle.
    assign wr_acc = i_w_inc & ~o_full  & ~i_flush;
    assign rd_acc = i_r_inc & ~o_empty & ~i_flush;

    // Storage array; flush leaves contents alone, only reset zeroes them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            mem[wptr] <= i_w_data;
        end
    end

    // Pointers wrap naturally at 2^A_SIZE; the separate count resolves the
    // full/empty ambiguity of equal pointers.
    always_ff @(posedge CLK) begin
        if (RST || i_flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_acc) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || i_flush) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags. They look at the raw request against the
    // start-of-cycle flag, so a write at full with a concurrent read still
    // reports overflow even though the read makes room.
    always_ff @(posedge CLK) begin
        if (RST || i_flush) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_w_inc && o_full) begin
                o_overflow <= 1'b1;
            end
            if (i_r_inc && o_empty) begin
                o_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; i_r_inc acknowledges it.
            assign o_r_data  = mem[rptr];
            assign o_r_valid = ~o_empty;
        end else begin : g_reg
            logic [D_SIZE-1:0] r_data_q;
            logic              r_valid_q;

            // One-cycle valid pulse per accepted read; data holds otherwise.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else if (i_flush) begin
                    r_valid_q <= 1'b0;
                end else begin
                    r_valid_q <= rd_acc;
                    if (rd_acc) begin
                        r_data_q <= mem[rptr];
                    end
                end
            end

            assign o_r_data  = r_data_q;
            assign o_r_valid = r_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one registered-read and one FWFT instance share the same stimulus.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: overflow/underflow are provoked deliberately and checked via the sticky flags.

module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       w_inc;
    logic [7:0] w_data;
    logic       r_inc;

    logic [7:0] rd0, rd1;
    logic       rv0, rv1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [3:0] cnt0, cnt1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_fifo #(.D_SIZE(8), .A_SIZE(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) u_reg (
        .CLK(clk), .RST(rst), .i_flush(flush), .i_w_inc(w_inc), .i_w_data(w_data),
        .i_r_inc(r_inc), .o_r_data(rd0), .o_r_valid(rv0), .o_full(full0), .o_empty(empty0),
        .o_almost_full(af0), .o_almost_empty(ae0), .o_count(cnt0),
        .o_overflow(ovf0), .o_underflow(unf0)
    );

    sync_fifo #(.D_SIZE(8), .A_SIZE(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) u_fwft (
        .CLK(clk), .RST(rst), .i_flush(flush), .i_w_inc(w_inc), .i_w_data(w_data),
        .i_r_inc(r_inc), .o_r_data(rd1), .o_r_valid(rv1), .o_full(full1), .o_empty(empty1),
        .o_almost_full(af1), .o_almost_empty(ae1), .o_count(cnt1),
        .o_overflow(ovf1), .o_underflow(unf1)
    );

    typedef struct {
        logic       f;
        logic       w;
        logic [7:0] wd;
        logic       r;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
        logic       rv;
        logic [7:0] rd;
        logic [7:0] head;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 unit later.
    task automatic cyc(input logic r_s, input logic f, input logic w, input logic [7:0] d,
                       input logic r);
        rst    = r_s;
        flush  = f;
        w_inc  = w;
        w_data = d;
        r_inc  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input logic [3:0] c, input logic fu,
                              input logic em, input logic a_f, input logic a_e,
                              input logic ov, input logic un);
        chk({tag, " status"}, {cnt0, full0, empty0, af0, ae0, ovf0, unf0},
            {c, fu, em, a_f, a_e, ov, un});
        chk({tag, " status fwft"}, {cnt1, full1, empty1, af1, ae1, ovf1, unf1},
            {c, fu, em, a_f, a_e, ov, un});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // {f, w, wd, r | cnt, full, empty, af, ae, ovf, unf, rv, rd, head}
        tbl[0]  = '{0, 1, 8'h11, 0, 4'd1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h11};
        tbl[1]  = '{0, 1, 8'h22, 0, 4'd2, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h11};
        tbl[2]  = '{0, 1, 8'h33, 0, 4'd3, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h11};
        tbl[3]  = '{0, 1, 8'h44, 0, 4'd4, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h11};
        tbl[4]  = '{0, 1, 8'h55, 0, 4'd5, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h11};
        tbl[5]  = '{0, 1, 8'h66, 0, 4'd6, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h11};
        tbl[6]  = '{0, 1, 8'h77, 0, 4'd7, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h11};
        tbl[7]  = '{0, 1, 8'h88, 0, 4'd8, 1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h11};
        tbl[8]  = '{0, 1, 8'hFF, 0, 4'd8, 1, 0, 1, 0, 1, 0, 0, 8'h00, 8'h11};
        tbl[9]  = '{0, 1, 8'h99, 1, 4'd7, 0, 0, 1, 0, 1, 0, 1, 8'h11, 8'h22};
        tbl[10] = '{0, 0, 8'h00, 0, 4'd7, 0, 0, 1, 0, 1, 0, 0, 8'h11, 8'h22};
        tbl[11] = '{0, 0, 8'h00, 1, 4'd6, 0, 0, 1, 0, 1, 0, 1, 8'h22, 8'h33};
        tbl[12] = '{0, 0, 8'h00, 1, 4'd5, 0, 0, 0, 0, 1, 0, 1, 8'h33, 8'h44};
        tbl[13] = '{0, 0, 8'h00, 1, 4'd4, 0, 0, 0, 0, 1, 0, 1, 8'h44, 8'h55};
        tbl[14] = '{0, 0, 8'h00, 1, 4'd3, 0, 0, 0, 0, 1, 0, 1, 8'h55, 8'h66};
        tbl[15] = '{0, 0, 8'h00, 1, 4'd2, 0, 0, 0, 0, 1, 0, 1, 8'h66, 8'h77};
        tbl[16] = '{0, 0, 8'h00, 1, 4'd1, 0, 0, 0, 1, 1, 0, 1, 8'h77, 8'h88};
        tbl[17] = '{0, 0, 8'h00, 1, 4'd0, 0, 1, 0, 1, 1, 0, 1, 8'h88, 8'h00};
        tbl[18] = '{0, 1, 8'h5A, 1, 4'd1, 0, 0, 0, 1, 1, 1, 0, 8'h88, 8'h5A};
        tbl[19] = '{0, 0, 8'h00, 1, 4'd0, 0, 1, 0, 1, 1, 1, 1, 8'h5A, 8'h00};
        tbl[20] = '{1, 0, 8'h00, 0, 4'd0, 0, 1, 0, 1, 0, 0, 0, 8'h5A, 8'h00};

        // Reset
        cyc(1, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 8'h00, 0);
        chk_status("reset", 4'd0, 0, 1, 0, 1, 0, 0);
        chk("reset rdata/rvalid", {rd0, rv0}, {8'h00, 1'b0});

        // Fill, overflow, full+both, drain, empty+both, flush
        for (int i = 0; i < 21; i++) begin
            cyc(0, tbl[i].f, tbl[i].w, tbl[i].wd, tbl[i].r);
            chk_status($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].full, tbl[i].empty,
                       tbl[i].af, tbl[i].ae, tbl[i].ovf, tbl[i].unf);
            chk($sformatf("vec%0d reg rdata/rvalid", i), {rd0, rv0}, {tbl[i].rd, tbl[i].rv});
            chk($sformatf("vec%0d fwft rvalid", i), {31'd0, rv1}, {31'd0, ~tbl[i].empty});
            if (!tbl[i].empty) begin
                chk($sformatf("vec%0d fwft head", i), {24'd0, rd1}, {24'd0, tbl[i].head});
            end
        end

        // Streaming across pointer wrap at constant occupancy 3
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 8'(k), 0);
        end
        for (int k = 0; k < 20; k++) begin
            cyc(0, 0, 1, 8'(k + 3), 1);
            chk($sformatf("stream%0d count", k), {28'd0, cnt0}, 32'd3);
            chk($sformatf("stream%0d reg data", k), {23'd0, rv0, rd0}, {23'd0, 1'b1, 8'(k)});
            chk($sformatf("stream%0d fwft head", k), {24'd0, rd1}, {24'd0, 8'(k + 1)});
        end
        cyc(0, 1, 0, 8'h00, 0);
        chk_status("stream flush", 4'd0, 0, 1, 0, 1, 0, 0);

        // FWFT presentation without a read, then acknowledge
        cyc(0, 0, 1, 8'hA5, 0);
        chk("fwft present", {23'd0, rv1, rd1}, {23'd0, 1'b1, 8'hA5});
        chk("fwft reg no pulse", {31'd0, rv0}, 32'd0);
        cyc(0, 0, 0, 8'h00, 1);
        chk("fwft ack", {30'd0, rv1, empty1}, {30'd0, 1'b0, 1'b1});
        chk("fwft ack reg data", {23'd0, rv0, rd0}, {23'd0, 1'b1, 8'hA5});

        // Flush with a concurrent write at count=5 with overflow set
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 1, 8'(8'h30 + k), 0);
        end
        cyc(0, 0, 1, 8'hFF, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 8'h00, 1);
        end
        chk_status("pre-flush", 4'd5, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 8'hEE, 0);
        chk_status("flush+write", 4'd0, 0, 1, 0, 1, 0, 0);
        chk("flush reg rvalid", {31'd0, rv0}, 32'd0);
        cyc(0, 0, 0, 8'h00, 0);
        chk("flush write dropped", {27'd0, rv1, cnt1}, {27'd0, 1'b0, 4'd0});
        cyc(0, 0, 1, 8'h44, 0);
        chk("post-flush head", {23'd0, rv1, rd1}, {23'd0, 1'b1, 8'h44});

        // Reset mid-stream, with an access requested in the reset cycle
        cyc(0, 0, 1, 8'h12, 1);
        chk("mid data", {23'd0, rv0, rd0}, {23'd0, 1'b1, 8'h44});
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 1);
        chk("mid underflow", {31'd0, unf0}, 32'd1);
        cyc(1, 0, 1, 8'h77, 1);
        chk_status("mid reset", 4'd0, 0, 1, 0, 1, 0, 0);
        chk("mid reset reg out", {23'd0, rv0, rd0}, 32'd0);
        chk("mid reset fwft out", {23'd0, rv1, rd1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO buffer with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush, and a selectable read mode (registered or first-word-fall-through). It is the same-domain companion of the dual-clock FIFO. It serves blocks whose producer and consumer share one clock, for example command queues in front of the register file and the ALU, and the TX staging buffer ahead of the UART.

## Interface
Parameters:
- D_SIZE, 8, data width in bits.
- A_SIZE, 3, address width; depth = 2^A_SIZE entries (A_SIZE >= 1).
- AF_LEVEL, 6, o_almost_full asserts when count >= AF_LEVEL (1..2^A_SIZE).
- AE_LEVEL, 1, o_almost_empty asserts when count <= AE_LEVEL (0..2^A_SIZE-1).
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
- CLK  in  1  single clock, all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- i_flush  in  1  synchronous flush, one-cycle pulse or level.
- i_w_inc  in  1  write request.
- i_w_data  in  D_SIZE  write data.
- i_r_inc  in  1  read request.
- o_r_data  out  D_SIZE  read data.
- o_r_valid  out  1  o_r_data holds a valid word (meaning depends on FWFT).
- o_full  out  1  count == 2^A_SIZE.
- o_empty  out  1  count == 0.
- o_almost_full  out  1  count >= AF_LEVEL.
- o_almost_empty  out  1  count <= AE_LEVEL.
- o_count  out  A_SIZE+1  current occupancy.
- o_overflow  out  1  sticky: a write was rejected.
- o_underflow  out  1  sticky: a read was rejected.

## Operation
- Storage: 2^A_SIZE x D_SIZE array, cleared to zero by RST. Flush does not clear it.
- Pointers: wptr and rptr are A_SIZE bits wide and wrap naturally from 2^A_SIZE-1 to 0. Occupancy is held in a separate count register, A_SIZE+1 bits wide.
- Write accept: wr_acc = i_w_inc & !o_full. On accept, mem[wptr] <= i_w_data and wptr increments.
- Read accept: rd_acc = i_r_inc & !o_empty. On accept, rptr increments.
- Flags use the registered state at the start of the cycle:
  - Full with simultaneous i_w_inc and i_r_inc: the read is accepted, the write is rejected, and overflow is set.
  - Empty with simultaneous i_w_inc and i_r_inc: the write is accepted, the read is rejected, and underflow is set.
- Count update: count <= count + wr_acc - rd_acc. Both accepted means count is unchanged.
- Sticky errors:
  - o_overflow sets on i_w_inc & o_full.
  - o_underflow sets on i_r_inc & o_empty.
  - Both clear only on RST or i_flush.
- FWFT=0:
  - On rd_acc, o_r_data <= mem[rptr] and o_r_valid <= 1 the next cycle (a one-cycle pulse per accepted read).
  - Otherwise o_r_valid <= 0 and o_r_data holds its last value.
- FWFT=1:
  - o_r_data = mem[rptr] combinationally; o_r_valid = !o_empty.
  - i_r_inc acts as an acknowledge for the presented word.
- Flush: when i_flush=1, wptr, rptr, count, o_overflow, o_underflow and (FWFT=0) o_r_valid all go to 0.
  - Flush overrides i_w_inc and i_r_inc in the same cycle; neither is accepted.
- Priority: RST > i_flush > normal operation.

## Timing
- Reset values (cycle after RST sampled high):
  - o_count=0, o_empty=1, o_full=0, o_almost_empty=1.
  - o_almost_full=0 (AF_LEVEL >= 1).
  - o_overflow=0, o_underflow=0, o_r_valid=0, o_r_data=0.
- All status outputs (o_full, o_empty, o_almost_*, o_count) are combinational decodes of registered count. They update on the edge that commits an access, with no extra lag.
- Write-to-read latency: a word written at edge N is readable (o_empty=0) after edge N.
  - FWFT=1: data is visible on o_r_data in the cycle after edge N.
  - FWFT=0: o_r_data is valid one cycle after the accepting read edge.
- Sustained throughput: one write and one read per cycle, with no bubbles at wrap-around.
- A request that is not accepted has no side effect except the sticky error flag.

## Test plan
- Reset then fill (A_SIZE=3, FWFT=0): write 0x11..0x88 on 8 consecutive cycles.
  - o_count steps 1..8.
  - o_almost_full rises when count=6; o_full rises when count=8.
  - o_almost_empty falls when count=2.
- Overflow: with full, pulse i_w_inc with 0xFF -> o_count stays 8, o_overflow=1 and stays high; a subsequent drain returns 0x11..0x88 and never 0xFF.
- Simultaneous access at the boundaries:
  - Full with both incs -> read returns 0x11, o_count=7, o_overflow set.
  - Empty with both incs -> o_count=1, o_underflow set, data written.
- Wrap and streaming: 20 cycles of simultaneous write (incrementing pattern) and read from count=3 -> o_count stays 3 and read data equals write data delayed by 3 accepts across a pointer wrap.
- FWFT=1: write 0xA5 into an empty FIFO -> next cycle o_r_valid=1 and o_r_data=0xA5 with no read; i_r_inc -> o_empty=1 and o_r_valid=0 after the edge.
- Flush in one cycle with i_w_inc=1 (count=5, o_overflow=1) -> o_count=0, o_empty=1, o_overflow=0, write not stored; RST mid-stream yields the full reset values.
